// File: rtl/hazard_pkg.sv
// Shared types and helpers for the MIPS hazard unit and its mult/div tracker.
package hazard_pkg;

  // Mult/div tracker states.
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // Forwarding selects for the E-stage ALU operands.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Latency of the op issuing in E: div uses the long latency, mult the short one.
  function automatic int lat_sel(input logic div, input int mulLat, input int divLat);
    if (div) begin
      return divLat;
    end else begin
      return mulLat;
    end
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Mult/div occupancy tracker: IDLE -> BUSY -> DONE -> IDLE.
// A start in cycle t gives MdBusy high t+1..t+LAT and a one-cycle MdDone at t+LAT.
// Starts seen outside IDLE are ignored (the checker flags them).
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic MdStartE,
  input  logic MdDivE,
  output logic MdBusy,
  output logic MdDone
);

  localparam int CW = $clog2(DIV_LAT);

  md_state_t       state_r;
  md_state_t       stateNext_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cntNext_s;
  logic            mdBusy_r;
  logic            mdDone_r;

  // Next-state and countdown; the load value leaves two cycles for the BUSY->DONE->IDLE tail.
  always_comb begin
    stateNext_s = state_r;
    cntNext_s   = cnt_r;
    case (state_r)
      MD_IDLE: begin
        if (MdStartE) begin
          stateNext_s = MD_BUSY;
          cntNext_s   = CW'(lat_sel(MdDivE, MUL_LAT, DIV_LAT) - 2);
        end else begin
          stateNext_s = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (cnt_r == {CW{1'b0}}) begin
          stateNext_s = MD_DONE;
        end else begin
          cntNext_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      MD_DONE: begin
        stateNext_s = MD_IDLE;
      end
      default: begin
        stateNext_s = MD_IDLE;
        cntNext_s   = {CW{1'b0}};
      end
    endcase
  end

  // State, counter and registered status flags; reset drops any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= MD_IDLE;
      cnt_r    <= {CW{1'b0}};
      mdBusy_r <= 1'b0;
      mdDone_r <= 1'b0;
    end else begin
      state_r  <= stateNext_s;
      cnt_r    <= cntNext_s;
      mdBusy_r <= (stateNext_s != MD_IDLE);
      mdDone_r <= (stateNext_s == MD_DONE);
    end
  end

  assign MdBusy = mdBusy_r;
  assign MdDone = mdDone_r;

endmodule

// File: rtl/md_busy_tracker_chk.sv
// Protocol checker for the mult/div tracker: a new mult/div must never reach E
// while the previous one still owns HI/LO (D should have been stalled).
module md_busy_tracker_chk (
  input logic clk,
  input logic reset,
  input logic MdStartE,
  input logic MdBusy
);

  // A mult/div issue while the tracker is busy means the stall logic was bypassed.
  mdStartWhileBusy: assert property (@(posedge clk) disable iff (reset) !(MdStartE && MdBusy));

endmodule

// File: rtl/hazard_sb_unit.sv
// Hazard unit for the 5-stage MIPS pipeline: RAW forwarding, load-use/branch
// stalls, mult/div structural and HI/LO stalls, and D flush on taken control flow.
// Optional statistics counters are built when HAZ_STATS_EN is defined.
module hazard_sb_unit
  import hazard_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             BranchTakenD,
  input  logic             JumpD,
  input  logic             MdStartD,
  input  logic             MdStartE,
  input  logic             MdDivE,
  input  logic             MfHiLoD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MdBusy,
  output logic             MdDone,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

  logic lwStall_s;
  logic brStallE_s;
  logic brStallM_s;
  logic brStall_s;
  logic mdStall_s;
  logic stall_s;

  // D-stage branch compare operands can only come from M.
  assign ForwardAD = (RsD != REG_ZERO) && (RsD == WriteRegM) && RegWriteM;
  assign ForwardBD = (RtD != REG_ZERO) && (RtD == WriteRegM) && RegWriteM;

  // E-stage operand A forwarding, M result has priority over W.
  always_comb begin
    if ((RsE != REG_ZERO) && (RsE == WriteRegM) && RegWriteM) begin
      ForwardAE = FWD_MEM;
    end else if ((RsE != REG_ZERO) && (RsE == WriteRegW) && RegWriteW) begin
      ForwardAE = FWD_WB;
    end else begin
      ForwardAE = FWD_RF;
    end
  end

  // E-stage operand B forwarding, M result has priority over W.
  always_comb begin
    if ((RtE != REG_ZERO) && (RtE == WriteRegM) && RegWriteM) begin
      ForwardBE = FWD_MEM;
    end else if ((RtE != REG_ZERO) && (RtE == WriteRegW) && RegWriteW) begin
      ForwardBE = FWD_WB;
    end else begin
      ForwardBE = FWD_RF;
    end
  end

  assign lwStall_s  = MemtoRegE && (RtE != REG_ZERO) && ((RsD == RtE) || (RtD == RtE));
  assign brStallE_s = RegWriteE && (WriteRegE != REG_ZERO) &&
                      ((WriteRegE == RsD) || (WriteRegE == RtD));
  assign brStallM_s = MemtoRegM && (WriteRegM != REG_ZERO) &&
                      ((WriteRegM == RsD) || (WriteRegM == RtD));
  assign brStall_s  = BranchD && (brStallE_s || brStallM_s);
  // A mult/div issuing this cycle blocks D just like one already in flight.
  assign mdStall_s  = (MfHiLoD || MdStartD) && (MdBusy || MdStartE);
  assign stall_s    = lwStall_s || brStall_s || mdStall_s;

  assign StallF = stall_s;
  assign StallD = stall_s;
  assign FlushE = stall_s;
  // A stalled D must keep its instruction, so the redirect flush waits for the stall to clear.
  assign FlushD = (JumpD || BranchTakenD) && !stall_s;

  md_busy_tracker #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) uTracker (
    .clk      (clk),
    .reset    (reset),
    .MdStartE (MdStartE),
    .MdDivE   (MdDivE),
    .MdBusy   (MdBusy),
    .MdDone   (MdDone)
  );

  md_busy_tracker_chk uTrackerChk (
    .clk      (clk),
    .reset    (reset),
    .MdStartE (MdStartE),
    .MdBusy   (MdBusy)
  );

`ifdef HAZ_STATS_EN
  logic [CNT_W-1:0] stallCnt_r;
  logic [CNT_W-1:0] flushCnt_r;

  // Saturating counts of stall cycles and D-flush cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt_r <= {CNT_W{1'b0}};
      flushCnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stallCnt_r != {CNT_W{1'b1}})) begin
        stallCnt_r <= stallCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (FlushD && (flushCnt_r != {CNT_W{1'b1}})) begin
        flushCnt_r <= flushCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign StallCnt = stallCnt_r;
  assign FlushCnt = flushCnt_r;
`else
  assign StallCnt = {CNT_W{1'b0}};
  assign FlushCnt = {CNT_W{1'b0}};
`endif

endmodule
